fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//  Instruction queue between the fetch unit and decode. Holds fetched
//  {PC, PC+4, instruction} triples so that fetch can keep running while decode
//  stalls. Also absorbs icache/data-memory busywait bubbles. Branch/jump
//  resolution flushes all queued wrong-path entries.
// PARAMETERS
//  DEPTH      4            number of entries; power of two, >=2
//  PTR_W      $clog2(DEPTH) pointer width; derived, do not override
//  NOP_INSTR  32'h00000013 value presented on out_instruction when empty (addi x0,x0,0)
// PORTS
//  clock            in   1    rising-edge clock
//  reset            in   1    asynchronous, active-low reset (0 = reset)
//  in_pc            in   32   PC of fetched instruction
//  in_pc_plus4      in   32   PC+4 of fetched instruction
//  in_instruction   in   32   fetched instruction word
//  in_valid         in   1    fetch presents a valid instruction this cycle (fetch not busywaiting)
//  flush            in   1    branch/jump taken; discard all entries
//  decode_ready     in   1    decode consumes head entry this cycle if out_valid
//  out_pc           out  32   PC of head entry
//  out_pc_plus4     out  32   PC+4 of head entry
//  out_instruction  out  32   instruction of head entry
//  out_valid        out  1    head entry valid
//  full             out  1    queue full; fetch must hold PC (OR into fetch stall)
//  count            out  PTR_W+1  number of valid entries, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH-entry register array of 96 bits. rd_ptr/wr_ptr are PTR_W bits
//    and wrap modulo DEPTH. The separate count register is the sole full/empty source.
//  - push = in_valid & ~full & ~flush;  pop = out_valid & decode_ready & ~flush.
//  - Push and pop are both evaluated on the rising clock edge:
//      push: mem[wr_ptr] <= {in_pc,in_pc_plus4,in_instruction}; wr_ptr++.
//      pop: rd_ptr++.
//      count <= count + push - pop.
//  - full = (count == DEPTH); out_valid = (count != 0); both decode state only.
//  - Head outputs are a combinational read of mem[rd_ptr] when out_valid.
//    When empty, outputs are: out_pc=0, out_pc_plus4=0, out_instruction=NOP_INSTR.
//  - Latency: an entry pushed at edge N is visible on the outputs after edge N.
//    There is no input-to-output bypass.
//  - Full with pop in the same cycle: the push is still rejected because full is
//    taken from current state. The slot frees at the edge; a push is accepted next cycle.
//  - Empty with decode_ready=1: no pop occurs and count stays 0 (no underflow).
//  - in_valid while full: the entry is not stored. Fetch holds the PC via full,
//    so that instruction is re-presented later.
//  - flush (priority over push and pop):
//      at the edge, rd_ptr <= 0, wr_ptr <= 0, count <= 0.
//      Any same-cycle in_valid entry is discarded; it is wrong-path.
//      out_valid = 0 and full = 0 after the edge. Memory contents need not be cleared.
//  - reset low (asynchronous, any time including mid-push):
//      immediately rd_ptr=0, wr_ptr=0, count=0.
//      All storage cleared to 0, so outputs go to the empty values.
//      No push or pop happens while reset is low. Normal operation starts at the
//      first rising edge after reset deasserts.
//  - Ordering is strict FIFO. No entry is duplicated or skipped across pointer wrap.
// STRUCTURE
//  - Shared package/header:
//      NOP_INSTR constant.
//      Entry field offsets: PC [95:64], PC+4 [63:32], INSTR [31:0].
//  - Single module, no sub-modules. The pointer/count logic is one always block
//    (async active-low reset). The read mux is one continuous assign.
//  - Integration: full is ORed into the fetch unit's busywait.
//    in_valid = ~fetch busywait. flush = branch_or_jump_signal.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles, then release.
//    -> count=0, out_valid=0, full=0, out_instruction=32'h00000013, out_pc=0.
//  2 Fill/drain: decode_ready=0; push PCs 0x00,0x04,0x08,0x0C with instrs 0xA0..0xA3.
//    -> full=1, count=4.
//    Then push 0x10 -> rejected.
//    Then decode_ready=1 -> outputs 0x00,0x04,0x08,0x0C in order.
//    -> count returns to 0.
//  3 Wrap: run 10 consecutive push+pop cycles at count=2.
//    -> count stays 2; outputs keep strict PC order across pointer wrap.
//  4 Full+pop same cycle: at count=4, assert in_valid and decode_ready together.
//    -> count=3; the new entry is absent.
//    Next cycle push -> count=4; it appears last.
//  5 Flush: at count=3, assert flush with in_valid=1 and decode_ready=1.
//    -> next cycle count=0, out_valid=0; the pushed entry never appears.
//  6 Async reset mid-operation: at count=2, pull reset low between clock edges.
//    -> count=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode instruction queue.
package fetch_decode_queue_pkg;

    // Instruction presented to decode when the queue is empty (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Field offsets inside one 96-bit queue entry.
    localparam int ENTRY_W    = 96;
    localparam int PC_LSB     = 64;
    localparam int PC4_LSB    = 32;
    localparam int INSTR_LSB  = 0;
    localparam int FIELD_W    = 32;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Pack one fetched triple into the entry layout.
    function automatic entry_t pack_entry(input logic [31:0] pc,
                                          input logic [31:0] pc_plus4,
                                          input logic [31:0] instr);
        return {pc, pc_plus4, instr};
    endfunction

    // Value the head read mux presents when nothing is queued.
    localparam entry_t EMPTY_ENTRY = {32'h0000_0000, 32'h0000_0000, NOP_INSTR};

endpackage

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode. Buffers {PC, PC+4, instr}
// triples so fetch keeps running while decode stalls; a taken branch or jump
// flushes every queued wrong-path entry. A dedicated count register is the
// only source of full/empty so pointer equality never has to be disambiguated.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_pc_plus4,
    input  logic [31:0]      in_instruction,
    input  logic             in_valid,
    input  logic             flush,
    input  logic             decode_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc_plus4,
    output logic [31:0]      out_instruction,
    output logic             out_valid,
    output logic             full,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;
    logic              push_s;
    logic              pop_s;
    entry_t            head_s;

    // full and valid decode the current count only, never the inputs.
    assign full      = (count_q == DEPTH_CNT);
    assign out_valid = (count_q != {(PTR_W + 1){1'b0}});
    assign count     = count_q;

    // Flush wins over both push and pop; a full queue rejects pushes even if a pop frees a slot this cycle.
    assign push_s = in_valid & ~full & ~flush;
    assign pop_s  = out_valid & decode_ready & ~flush;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
            2'b11:   count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; flush rewinds everything to the empty state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head read is clean, left as-is on flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= pack_entry(in_pc, in_pc_plus4, in_instruction);
        end
    end

    // Head read: stored entry when something is queued, NOP triple otherwise.
    assign head_s = out_valid ? mem_q[rd_ptr_q] : EMPTY_ENTRY;

    assign out_pc          = head_s[PC_LSB    +: FIELD_W];
    assign out_pc_plus4    = head_s[PC4_LSB   +: FIELD_W];
    assign out_instruction = head_s[INSTR_LSB +: FIELD_W];

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue.
module tb_fetch_decode_queue;

    logic        clock;
    logic        reset;
    logic [31:0] in_pc;
    logic [31:0] in_pc_plus4;
    logic [31:0] in_instruction;
    logic        in_valid;
    logic        flush;
    logic        decode_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instruction;
    logic        out_valid;
    logic        full;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_decode_queue #(.DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_pc           (in_pc),
        .in_pc_plus4     (in_pc_plus4),
        .in_instruction  (in_instruction),
        .in_valid        (in_valid),
        .flush           (flush),
        .decode_ready    (decode_ready),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .out_instruction (out_instruction),
        .out_valid       (out_valid),
        .full            (full),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a fetch triple (valid) for the coming edge.
    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic vld, input logic rdy, input logic fl);
        in_pc          = pc;
        in_pc_plus4    = pc + 32'd4;
        in_instruction = instr;
        in_valid       = vld;
        decode_ready   = rdy;
        flush          = fl;
    endtask

    task automatic test_reset();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (out_instruction !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", out_instruction); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
        checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", out_pc_plus4); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            drive(32'(i * 4), 32'hA0 + 32'(i), 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got valid=%b exp 0", out_valid); end
            end
            step();
            if (i == 0) begin
                checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL first_visible got pc=%h v=%b exp 0/1", out_pc, out_valid); end
            end
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        drive(32'h10, 32'hA4, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL reject_count got %0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (out_pc !== 32'(i * 4) || out_pc_plus4 !== 32'(i * 4 + 4) || out_instruction !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL drain_%0d got pc=%h pc4=%h ins=%h exp pc=%h", i, out_pc, out_pc_plus4, out_instruction, 32'(i * 4));
            end
            step();
        end
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got count=%0d v=%b exp 0/0", count, out_valid); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL no_underflow got %0d exp 0", count); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [31:0] next_push;
        logic [31:0] next_head;
        next_push = 32'h100;
        next_head = 32'h100;
        for (int i = 0; i < 2; i++) begin
            drive(next_push, next_push ^ 32'hFFFF_0000, 1'b1, 1'b0, 1'b0);
            step();
            next_push = next_push + 32'd4;
        end
        for (int i = 0; i < 10; i++) begin
            drive(next_push, next_push ^ 32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
            checks++;
            if (out_pc !== next_head || out_instruction !== (next_head ^ 32'hFFFF_0000)) begin
                errors++;
                $display("FAIL wrap_order_%0d got pc=%h ins=%h exp pc=%h", i, out_pc, out_instruction, next_head);
            end
            step();
            next_push = next_push + 32'd4;
            next_head = next_head + 32'd4;
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL wrap_count_%0d got %0d exp 2", i, count); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            checks++; if (out_pc !== next_head) begin errors++; $display("FAIL wrap_tail_%0d got %h exp %h", i, out_pc, next_head); end
            step();
            next_head = next_head + 32'd4;
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_pc [4];
        for (int i = 0; i < 4; i++) begin
            drive(32'h200 + 32'(i * 4), 32'hB0 + 32'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(32'h210, 32'hB4, 1'b1, 1'b1, 1'b0);
        checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL fullpop_head got %h exp 200", out_pc); end
        step();
        checks++; if (count !== 3'd3 || full !== 1'b0) begin errors++; $display("FAIL fullpop_count got %0d full=%b exp 3/0", count, full); end
        drive(32'h214, 32'hB5, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_refill got %0d exp 4", count); end
        exp_pc[0] = 32'h204; exp_pc[1] = 32'h208; exp_pc[2] = 32'h20C; exp_pc[3] = 32'h214;
        for (int i = 0; i < 4; i++) begin
            drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
            checks++; if (out_pc !== exp_pc[i]) begin errors++; $display("FAIL fullpop_order_%0d got %h exp %h", i, out_pc, exp_pc[i]); end
            step();
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", count); end
        drive(32'h3FC, 32'hDEAD, 1'b1, 1'b1, 1'b1);
        step();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL flush_empty got count=%0d v=%b f=%b exp 0/0/0", count, out_valid, full); end
        checks++; if (out_instruction !== 32'h0000_0013) begin errors++; $display("FAIL flush_nop got %h exp 00000013", out_instruction); end
        drive(32'h400, 32'hC8, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (out_pc !== 32'h400 || count !== 3'd1) begin errors++; $display("FAIL flush_next got pc=%h count=%0d exp 400/1", out_pc, count); end
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(32'h500 + 32'(i * 4), 32'hE0 + 32'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(32'h508, 32'hE2, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL areset_pre got %0d exp 2", count); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_now got count=%0d v=%b exp 0/0", count, out_valid); end
        checks++; if (out_pc !== 32'h0 || out_instruction !== 32'h0000_0013) begin errors++; $display("FAIL areset_out got pc=%h ins=%h exp 0/00000013", out_pc, out_instruction); end
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_hold got %0d exp 0", count); end
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_after got count=%0d v=%b exp 0/0", count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
